// File: rtl/gcd_ctrl.sv
// gcd_ctrl: Moore controller for a subtract-based GCD datapath.
//   Loads both operands, then repeatedly subtracts the smaller register from
//   the larger one until they are equal. It strobes the result register and
//   reports completion over a four-phase go/done handshake. A run aborts with
//   err if MAX_ITER subtractions pass without the operands becoming equal.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous active-high reset
//   go        in   1      start request (four-phase with done)
//   lt        in   1      datapath comparator: x < y
//   neq       in   1      datapath comparator: x != y
//   x_sel     out  1      x mux select: 0 = external operand, 1 = x-y
//   y_sel     out  1      y mux select: 0 = external operand, 1 = y-x
//   x_ld      out  1      x register load enable
//   y_ld      out  1      y register load enable
//   d_ld      out  1      result register load enable (captures x)
//   busy      out  1      run in progress (INIT/CMP/SUBX/SUBY/FIN)
//   done      out  1      run finished (DONE or FAIL)
//   err       out  1      run aborted on the iteration limit (FAIL)
//   iter_cnt  out  CNT_W  subtractions performed in the current/last run
module gcd_ctrl #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned MAX_ITER = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             lt,
  input  logic             neq,
  output logic             x_sel,
  output logic             y_sel,
  output logic             x_ld,
  output logic             y_ld,
  output logic             d_ld,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CMP,
    S_SUBX,
    S_SUBY,
    S_FIN,
    S_DONE,
    S_FAIL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             x_sel_nxt;
  logic             y_sel_nxt;
  logic             x_ld_nxt;
  logic             y_ld_nxt;
  logic             d_ld_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             err_nxt;

  // State, counter and output registers. Outputs are the decode of the
  // next state, so each registered output lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      x_sel    <= 1'b0;
      y_sel    <= 1'b0;
      x_ld     <= 1'b0;
      y_ld     <= 1'b0;
      d_ld     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= cnt_nxt;
      x_sel    <= x_sel_nxt;
      y_sel    <= y_sel_nxt;
      x_ld     <= x_ld_nxt;
      y_ld     <= y_ld_nxt;
      d_ld     <= d_ld_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  // Next-state, counter update and Moore output decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = iter_cnt;
    x_sel_nxt = 1'b0;
    y_sel_nxt = 1'b0;
    x_ld_nxt  = 1'b0;
    y_ld_nxt  = 1'b0;
    d_ld_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (go) state_nxt = S_INIT;
      end
      S_INIT: begin
        cnt_nxt   = '0;
        state_nxt = S_CMP;
      end
      S_CMP: begin
        // Equality wins over the limit, so a run that converges on its last
        // permitted subtraction still finishes cleanly.
        if (!neq)                    state_nxt = S_FIN;
        else if (iter_cnt == MAX_CNT) state_nxt = S_FAIL;
        else if (lt)                 state_nxt = S_SUBY;
        else                         state_nxt = S_SUBX;
      end
      S_SUBX, S_SUBY: begin
        // The limit check in CMP keeps this from ever wrapping.
        cnt_nxt   = iter_cnt + CNT_W'(1);
        state_nxt = S_CMP;
      end
      S_FIN: begin
        state_nxt = S_DONE;
      end
      S_DONE, S_FAIL: begin
        if (!go) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    case (state_nxt)
      S_INIT: begin
        x_ld_nxt = 1'b1;
        y_ld_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      S_CMP: begin
        busy_nxt = 1'b1;
      end
      S_SUBX: begin
        x_sel_nxt = 1'b1;
        x_ld_nxt  = 1'b1;
        busy_nxt  = 1'b1;
      end
      S_SUBY: begin
        y_sel_nxt = 1'b1;
        y_ld_nxt  = 1'b1;
        busy_nxt  = 1'b1;
      end
      S_FIN: begin
        d_ld_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      S_DONE: begin
        done_nxt = 1'b1;
      end
      S_FAIL: begin
        done_nxt = 1'b1;
        err_nxt  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: directed bench for gcd_ctrl with a 4-bit GCD datapath around
// it. A run-level model (Euclid by subtraction on plain integers) predicts
// the per-cycle outputs; literal expectations pin the model's results.
module tb_gcd_ctrl;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MAX_ITER = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic             lt;
  logic             neq;
  logic             x_sel;
  logic             y_sel;
  logic             x_ld;
  logic             y_ld;
  logic             d_ld;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter_cnt;

  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] x_r;
  logic [3:0] y_r;
  logic [3:0] d_r;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // run-level model state
  bit   active = 1'b0;
  int   e0;
  int   m_n;
  bit   m_fail;
  int   m_res;
  int   m_prev_cnt = 0;
  bit   dirx [1:16];
  int   done_t;
  int   dld_pulses;

  gcd_ctrl #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .lt       (lt),
    .neq      (neq),
    .x_sel    (x_sel),
    .y_sel    (y_sel),
    .x_ld     (x_ld),
    .y_ld     (y_ld),
    .d_ld     (d_ld),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .iter_cnt (iter_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // datapath: x/y registers with subtractor muxes, result register, comparator
  always @(posedge clk) begin
    if (x_ld) x_r <= x_sel ? 4'(x_r - y_r) : a_in;
    if (y_ld) y_r <= y_sel ? 4'(y_r - x_r) : b_in;
    if (d_ld) d_r <= x_r;
  end
  assign lt  = (x_r < y_r);
  assign neq = (x_r != y_r);

  function automatic int outs();
    return int'({x_sel, y_sel, x_ld, y_ld, d_ld, busy, done, err});
  endfunction

  task automatic chk(input string name, input int act, input int exp, input int t);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d got 0x%0h want 0x%0h", name, t, act, exp);
    end
  endtask

  // Euclid by repeated subtraction with the iteration limit.
  task automatic model_run(input int a, input int b);
    int aa;
    int bb;
    aa = a;
    bb = b;
    m_n    = 0;
    m_fail = 1'b0;
    while (aa != bb) begin
      if (m_n == int'(MAX_ITER)) begin
        m_fail = 1'b1;
        break;
      end
      m_n++;
      dirx[m_n] = (aa > bb);
      if (aa > bb) aa -= bb;
      else         bb -= aa;
    end
    m_res = aa;
  endtask

  // Per-cycle comparison against the model while a run is active.
  task automatic compare_loop();
    int t;
    int j;
    int exp_o;
    int exp_c;
    forever begin
      @(negedge clk);
      if (active) begin
        t = cyc - e0 + 1;
        if (t == 1) exp_o = 'b00110100;
        else if (t <= 2 * m_n + 2) begin
          if (t % 2 == 0) exp_o = 'b00000100;
          else begin
            j = (t - 1) / 2;
            exp_o = dirx[j] ? 'b10100100 : 'b01010100;
          end
        end
        else if (!m_fail && t == 2 * m_n + 3) exp_o = 'b00001100;
        else exp_o = m_fail ? 'b00000011 : 'b00000010;
        if (t == 1) exp_c = m_prev_cnt;
        else exp_c = ((t - 2) / 2 < m_n) ? (t - 2) / 2 : m_n;
        chk("outs", outs(), exp_o, t);
        chk("iter_cnt", int'(iter_cnt), exp_c, t);
        if (d_ld) dld_pulses++;
        if (done && done_t == 0) done_t = t;
      end
    end
  endtask

  task automatic start_op(input int a, input int b);
    @(negedge clk);
    #1;
    a_in = 4'(a);
    b_in = 4'(b);
    go   = 1'b1;
    model_run(a, b);
    e0         = cyc + 1;
    done_t     = 0;
    dld_pulses = 0;
    active     = 1'b1;
  endtask

  task automatic run_op(input int a, input int b, input int hold,
                        input int lit_res, input int lit_cnt,
                        input int lit_done_t, input bit lit_fail);
    int w;
    start_op(a, b);
    w = 0;
    while (!done && w < 80) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("done_seen", int'(done), 1, w);
    repeat (hold - 1) begin
      @(negedge clk);
      #1;
    end
    go     = 1'b0;
    active = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_outs", outs(), 0, 0);
    chk("idle_cnt", int'(iter_cnt), m_n, 0);
    chk("lit_cnt", m_n, lit_cnt, 0);
    chk("lit_fail", int'(m_fail), int'(lit_fail), 0);
    chk("lit_done_t", done_t, lit_done_t, 0);
    chk("dld_pulses", dld_pulses, lit_fail ? 0 : 1, 0);
    if (!lit_fail) chk("result", int'(d_r), lit_res, 0);
    m_prev_cnt = m_n;
  endtask

  initial begin
    fork
      compare_loop();
    join_none

    // reset held with go asserted
    rst  = 1'b1;
    go   = 1'b1;
    a_in = 4'd12;
    b_in = 4'd8;
    repeat (2) begin
      @(negedge clk);
      chk("rst_outs", outs(), 0, 0);
      chk("rst_cnt", int'(iter_cnt), 0, 0);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_after_rst", outs(), 'b00110100, 1);
    #1;
    rst = 1'b1;
    go  = 1'b0;
    @(negedge clk);
    chk("rst_again", outs(), 0, 0);
    #1 rst = 1'b0;

    run_op(12, 8, 1, 4, 2, 8, 1'b0);
    run_op(7, 7, 5, 7, 0, 4, 1'b0);
    run_op(15, 1, 1, 1, 14, 32, 1'b0);
    run_op(5, 0, 2, 0, 15, 33, 1'b1);

    // reset during SUBX of (12,8)
    start_op(12, 8);
    repeat (3) @(negedge clk);
    #1;
    rst    = 1'b1;
    go     = 1'b0;
    active = 1'b0;
    @(negedge clk);
    chk("midrun_rst_outs", outs(), 0, 0);
    chk("midrun_rst_cnt", int'(iter_cnt), 0, 0);
    #1 rst = 1'b0;
    m_prev_cnt = 0;

    // go held in DONE for 5 cycles, then released
    run_op(9, 6, 5, 3, 2, 8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
